// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
package if_prefetch_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/if_queue_fifo.sv
// In-order circular buffer of {pc, inst} entries with flush and occupancy.
module if_queue_fifo
    import if_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [XLEN-1:0]          push_pc,
    input  logic [XLEN-1:0]          push_inst,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [XLEN-1:0]          head_pc,
    output logic [XLEN-1:0]          head_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] inst_q [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic            do_pop;

    assign do_pop     = pop && (count != '0);
    assign head_valid = (count != '0);
    assign head_pc    = pc_q[head];
    assign head_inst  = inst_q[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc_q[tail]   <= push_pc;
                inst_q[tail] <= push_inst;
                tail         <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch front end: one-outstanding sequential imem reads feeding an in-order
// queue toward ID, with redirect flush and stale-response discard.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_ack,
    input  logic [XLEN-1:0]        imem_rdata,
    output logic                   id_valid,
    output logic [XLEN-1:0]        id_inst,
    output logic [XLEN-1:0]        id_pc,
    input  logic                   id_ready,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    input  logic                   halt,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int             CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    fetch_state_t    state;
    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] fpc_inc;
    logic            push;
    logic            pop;
    logic [CW-1:0]   occ_next;
    logic            room_next;

    assign fpc_inc   = fpc + 32'd4;
    assign push      = (state == WAIT) && imem_ack && !redirect;
    assign pop       = id_valid && id_ready;
    assign occ_next  = occupancy + CW'(push) - CW'(pop);
    // Back-to-back issue needs a free slot for the next in-flight word.
    assign room_next = (occ_next < FULL);

    if_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_pc    (fpc),
        .push_inst  (imem_rdata),
        .pop        (pop),
        .head_valid (id_valid),
        .head_pc    (id_pc),
        .head_inst  (id_inst),
        .count      (occupancy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            if (redirect) begin
                fpc <= redirect_pc;
            end
            unique case (state)
                IDLE: begin
                    if (!redirect && !halt && (occupancy < FULL)) begin
                        state     <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= fpc;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            state <= DROP;
                        end
                    end else if (imem_ack) begin
                        fpc <= fpc_inc;
                        if (room_next && !halt) begin
                            imem_addr <= fpc_inc;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                // Old address held until the memory answers; word is thrown away.
                DROP: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed self-checking bench for if_prefetch_queue with a latency-
// configurable instruction memory model.
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [2:0]  occupancy;

    int n_run  = 0;
    int n_fail = 0;
    int lat    = 0;
    int wcnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    // Memory answers after lat wait cycles of a held request.
    always @(posedge clk or negedge reset) begin
        if (!reset) wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    assign imem_ack   = imem_req && (wcnt >= lat);
    assign imem_rdata = imem_ack ? word_at(imem_addr) : 32'hDEAD_BEEF;

    if_prefetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .occupancy   (occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start(input int l, input logic rdy);
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        id_ready    = rdy;
        lat         = l;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        int found;
        logic [31:0] first_addr;

        // streaming with zero-latency memory, including reset values
        start(0, 1'b1);
        reset = 1'b0;
        tick();
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0040_0000);
        chk("rst_occ", 32'(occupancy), 32'd0);
        reset = 1'b1;
        tick();
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr", imem_addr, 32'h0040_0000);
        chk("t1_valid0", 32'(id_valid), 32'd0);
        tick();
        chk("t1_inst", id_inst, word_at(32'h0040_0000));
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", 32'(id_valid), 32'd1);
            chk("t1_pc", id_pc, 32'h0040_0000 + 32'(4 * i));
            chk("t1_occ", 32'(occupancy), 32'd1);
            tick();
        end

        // fill with stalled ID, then drain in order
        start(0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk("t2_full", 32'(occupancy), 32'd4);
        chk("t2_noreq", 32'(imem_req), 32'd0);
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_valid", 32'(id_valid), 32'd1);
            chk("t2_pc", id_pc, 32'h0040_0000 + 32'(4 * i));
            tick();
        end

        // redirect while a slow request is in flight
        start(3, 1'b1);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0100;
        tick();
        redirect = 1'b0;
        chk("t3_drop_req", 32'(imem_req), 32'd1);
        chk("t3_drop_addr", imem_addr, 32'h0040_0000);
        stale      = 0;
        found      = 0;
        first_addr = 32'h0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            tick();
            if (imem_req && imem_addr != 32'h0040_0000 && first_addr == 32'h0)
                first_addr = imem_addr;
            if (id_valid) begin
                found = 1;
                if (id_pc != 32'h0040_0100) stale++;
            end
        end
        chk("t3_seen", 32'(found), 32'd1);
        chk("t3_addr", first_addr, 32'h0040_0100);
        chk("t3_pc", id_pc, 32'h0040_0100);
        chk("t3_stale", 32'(stale), 32'd0);

        // redirect + ack + pop in one cycle with two entries queued
        start(0, 1'b0);
        tick();
        tick();
        tick();
        chk("t4_occ2", 32'(occupancy), 32'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h0050_0000;
        id_ready    = 1'b1;
        tick();
        redirect = 1'b0;
        chk("t4_occ0", 32'(occupancy), 32'd0);
        chk("t4_valid", 32'(id_valid), 32'd0);
        chk("t4_idle", 32'(imem_req), 32'd0);
        tick();
        chk("t4_req", 32'(imem_req), 32'd1);
        chk("t4_addr", imem_addr, 32'h0050_0000);
        tick();
        chk("t4_pc", id_pc, 32'h0050_0000);
        chk("t4_v1", 32'(id_valid), 32'd1);

        // asynchronous reset in the middle of fetching
        start(0, 1'b0);
        tick();
        tick();
        tick();
        #3;
        reset = 1'b0;
        #1;
        chk("t5_occ", 32'(occupancy), 32'd0);
        chk("t5_valid", 32'(id_valid), 32'd0);
        chk("t5_pc", id_pc, 32'h0);
        chk("t5_req", 32'(imem_req), 32'd0);
        chk("t5_addr", imem_addr, 32'h0040_0000);
        tick();
        reset = 1'b1;
        tick();
        chk("t5_req2", 32'(imem_req), 32'd1);
        chk("t5_addr2", imem_addr, 32'h0040_0000);

        // halt with an in-flight request, drain, then PC wrap
        start(0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        chk("t6_occ3", 32'(occupancy), 32'd3);
        chk("t6_addr", imem_addr, 32'h0040_000C);
        halt = 1'b1;
        lat  = 2;
        tick();
        chk("t6_inflight", 32'(imem_req), 32'd1);
        tick();
        tick();
        chk("t6_occ4", 32'(occupancy), 32'd4);
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req) stale++;
            tick();
        end
        chk("t6_noreq", 32'(stale), 32'd0);
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t6_pc", id_pc, 32'h0040_0000 + 32'(4 * i));
            tick();
        end
        chk("t6_empty", 32'(occupancy), 32'd0);
        chk("t6_valid", 32'(id_valid), 32'd0);
        chk("t6_halted", 32'(imem_req), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        halt        = 1'b0;
        lat         = 0;
        id_ready    = 1'b0;
        tick();
        redirect = 1'b0;
        tick();
        chk("t6_wreq", 32'(imem_req), 32'd1);
        chk("t6_waddr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t6_wrap", imem_addr, 32'h0000_0000);
        chk("t6_wpc", id_pc, 32'hFFFF_FFFC);
        chk("t6_winst", id_inst, word_at(32'hFFFF_FFFC));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the ID stage.
- Issues sequential instruction-memory reads and buffers returned words with their PCs in a small in-order queue.
- Delivers entries to ID over a valid/ready handshake; ID stalls (bubble) by deasserting ready.
- Branch/jump redirects from ID flush the queue and restart fetch at the target. Stale in-flight responses are discarded.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
RESET_PC, 32'h00400000, first fetch address after reset

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  read request, level, held until imem_ack
imem_addr  out  32  word-aligned fetch address, stable while imem_req=1
imem_ack  in  1  response valid; may coincide with the imem_req cycle (combinational memory)
imem_rdata  in  32  instruction word, valid when imem_ack=1
id_valid  out  1  head entry valid
id_inst  out  32  head entry instruction
id_pc  out  32  head entry PC
id_ready  in  1  ID consumes head this cycle (pop when id_valid & id_ready)
redirect  in  1  flush and restart fetch
redirect_pc  in  32  new fetch PC
halt  in  1  stop starting new requests (BREAK)
occupancy  out  3  valid entry count, 0..DEPTH

Behaviour:
- Reset (async, while low):
  - id_valid=0, id_inst=0, id_pc=0, imem_req=0, imem_addr=RESET_PC, occupancy=0.
  - Pointers=0, fpc=RESET_PC, state=IDLE.
- Storage:
  - Circular buffer. Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - id_inst/id_pc are driven directly from the head entry (registered storage, no added latency).
- One outstanding request at most. FSM states:
  - IDLE: if !halt & (occupancy<DEPTH) & !redirect → WAIT with imem_addr=fpc.
  - WAIT: imem_req=1.
    - On imem_ack without redirect: push {fpc, imem_rdata}; fpc+=4 (32-bit wrap, FFFFFFFC→0).
    - Then, if space remains after this cycle's push/pop and !halt, stay in WAIT with the new address (back-to-back, one word per cycle). Otherwise → IDLE.
  - WAIT + redirect, no ack: → DROP; fpc=redirect_pc.
  - WAIT + redirect + ack same cycle: response discarded; fpc=redirect_pc; → IDLE.
  - DROP: imem_req stays 1 with the old address until imem_ack. The response is discarded, then → IDLE.
    - A further redirect in DROP only updates fpc.
- Space check counts the in-flight slot: a request starts only if occupancy + pending < DEPTH. A push never meets a full queue.
- Pop: head advances when id_valid & id_ready.
- Simultaneous push and pop: occupancy unchanged.
- Redirect priority: redirect > push > pop.
  - Redirect empties the queue: occupancy=0 and id_valid=0 from the next cycle.
  - A pop in the same cycle is accepted by ID but irrelevant.
- Latency: with imem_ack in the request cycle, the first request is asserted in the first clock after reset release. id_valid rises on the following edge.
  - After a redirect from IDLE: first request next cycle; first entry valid one cycle after its ack.
- halt:
  - No new request starts.
  - An in-flight request completes and pushes (unless flushed).
  - The queue continues to drain.
  - Deasserting halt resumes at fpc.
- Reset mid-operation: immediate return to reset values. An ack arriving during reset is ignored.

Decomposition:
- Shared package holds:
  - FSM state enum {IDLE, WAIT, DROP}.
  - RESET_PC default constant.
  - Instruction/PC width constant (32).
- Natural sub-module: if_queue_fifo — circular buffer with push/pop/flush and occupancy. The FSM and fpc stay in the top.

Test Plan:
- Release reset; imem_ack=1 every cycle; id_ready=1 → id_pc sequence 0x00400000, 0x00400004, 0x00400008, one per cycle; id_valid first high the cycle after the first request.
- id_ready=0, zero-latency memory → occupancy reaches 4, then imem_req=0; set id_ready=1 → entries drain in PC order with no gaps or duplicates, and fetch resumes.
- Memory latency 3; redirect to 0x00400100 in the 2nd WAIT cycle → stale word never appears; next imem_addr=0x00400100; first id_pc=0x00400100.
- Queue holding 2 entries; redirect, imem_ack and pop in the same cycle → occupancy=0 and id_valid=0 next cycle; next request is to redirect_pc.
- Reset pulled low mid-WAIT → outputs reset immediately (no clock); after release, first imem_addr=0x00400000.
- halt=1 with 3 entries and one in flight → in-flight word pushed (occupancy 4 if no pops), no further imem_req, queue drains to 0; fpc=0xFFFFFFFC with ack → next imem_addr=0x00000000.
